// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one single-ported boot ROM between the fetch (imem) and load (dmem) ports
// Ports:
//   clock, reset         clock and asynchronous active-low reset
//   imem_valid/addr      fetch request pulse and address; imem_ready/rdata completion pulse and data
//   dmem_valid/addr      load request pulse and address;  dmem_ready/rdata completion pulse and data
//   rom_valid/instr/addr request to the ROM (instr=1 for fetch); rom_ready/rdata ROM completion
module rom_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              imem_valid,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_rdata,
    output logic              imem_ready,
    input  logic              dmem_valid,
    input  logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_rdata,
    output logic              dmem_ready,
    output logic              rom_valid,
    output logic              rom_instr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_rdata,
    input  logic              rom_ready
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state_q, state_d;
    logic owner_q, owner_d, last_q, last_d, pend_i_q, pend_i_d, pend_d_q, pend_d_d;
    logic [ADDR_W-1:0] addr_i_q, addr_i_d, addr_d_q, addr_d_d;
    logic busy, done, acc_i, acc_d, req_i, req_d, can_grant, gnt_i, gnt_d;
    logic [ADDR_W-1:0] cand_i, cand_d;
    // owner_q/last_q: 1 = fetch port, 0 = load port
    always_comb begin
        busy       = state_q == WAIT;
        done       = busy & rom_ready;
        // a valid on a port already pending or outstanding is dropped
        acc_i      = imem_valid & ~pend_i_q & ~(busy & owner_q);
        acc_d      = dmem_valid & ~pend_d_q & ~(busy & ~owner_q);
        req_i      = pend_i_q | acc_i;
        req_d      = pend_d_q | acc_d;
        cand_i     = pend_i_q ? addr_i_q : imem_addr;
        cand_d     = pend_d_q ? addr_d_q : dmem_addr;
        // reset gates the combinational issue path so outputs stay 0 in reset
        can_grant  = reset & (~busy | rom_ready);
        gnt_i      = can_grant & req_i & (~req_d | ~last_q);
        gnt_d      = can_grant & req_d & ~gnt_i;
        rom_valid  = gnt_i | gnt_d;
        rom_instr  = gnt_i;
        rom_addr   = gnt_i ? cand_i : gnt_d ? cand_d : '0;
        imem_ready = done & owner_q;
        dmem_ready = done & ~owner_q;
        imem_rdata = imem_ready ? rom_rdata : '0;
        dmem_rdata = dmem_ready ? rom_rdata : '0;
        pend_i_d   = ~gnt_i & req_i;
        pend_d_d   = ~gnt_d & req_d;
        addr_i_d   = (acc_i & ~gnt_i) ? imem_addr : addr_i_q;
        addr_d_d   = (acc_d & ~gnt_d) ? dmem_addr : addr_d_q;
        state_d    = (rom_valid | (busy & ~rom_ready)) ? WAIT : IDLE;
        owner_d    = rom_valid ? gnt_i : owner_q;
        last_d     = rom_valid ? gnt_i : last_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b0;
            pend_i_q <= 1'b0;
            pend_d_q <= 1'b0;
            addr_i_q <= '0;
            addr_d_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            pend_i_q <= pend_i_d;
            pend_d_q <= pend_d_d;
            addr_i_q <= addr_i_d;
            addr_d_q <= addr_d_d;
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed and randomized checks of rom_arbiter against a port-level reference model
module tb_rom_arbiter;
    logic clock = 1'b0, reset = 1'b0;
    logic imem_valid = 1'b0, dmem_valid = 1'b0, rom_ready = 1'b0;
    logic [31:0] imem_addr = '0, dmem_addr = '0, rom_rdata = '0;
    logic [31:0] imem_rdata, dmem_rdata, rom_addr;
    logic imem_ready, dmem_ready, rom_valid, rom_instr;
    always #5 clock = ~clock;
    rom_arbiter #(.ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .rom_valid(rom_valid), .rom_instr(rom_instr), .rom_addr(rom_addr),
        .rom_rdata(rom_rdata), .rom_ready(rom_ready)
    );
    logic [31:0] rom_mem [32];
    int checks = 0, errors = 0;
    // ROM environment
    bit rom_busy = 0, spurious = 0;
    logic [31:0] rom_lat = '0;
    int stall = 0;
    // reference model: port 0 = fetch, 1 = load, owner -1 = nothing outstanding
    int owner = -1, last = 1;
    bit pv[2];
    logic [31:0] pa[2];
    int grants[$];
    int seen_ready[2];
    logic o_iready, o_dready, o_rv, o_instr;
    logic [31:0] o_irdata, o_drdata, o_addr;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic rom_drive();
        rom_ready = (rom_busy && stall == 0) || spurious;
        rom_rdata = rom_ready ? rom_mem[rom_lat[6:2]] : $urandom;
    endtask
    task automatic rom_update();
        if (rom_ready) rom_busy = 0;
        else if (rom_busy && stall > 0) stall--;
        if (rom_valid) begin
            rom_busy = 1;
            rom_lat  = rom_addr;
        end
    endtask
    task automatic cycle(input bit iv, input logic [31:0] ia, input bit dv, input logic [31:0] da);
        bit vin[2], fresh[2], cand[2], done;
        logic [31:0] ain[2], caddr[2];
        int win;
        imem_valid = iv; imem_addr = ia; dmem_valid = dv; dmem_addr = da;
        rom_drive();
        #3;
        vin[0] = iv; vin[1] = dv; ain[0] = ia; ain[1] = da;
        for (int p = 0; p < 2; p++) begin
            fresh[p] = vin[p] && !pv[p] && owner != p;
            cand[p]  = pv[p] || fresh[p];
            caddr[p] = pv[p] ? pa[p] : ain[p];
        end
        done = owner >= 0 && rom_ready;
        win = -1;
        if (owner < 0 || rom_ready)
            win = (cand[0] && cand[1]) ? 1 - last : cand[0] ? 0 : cand[1] ? 1 : -1;
        o_iready = imem_ready; o_dready = dmem_ready; o_irdata = imem_rdata; o_drdata = dmem_rdata;
        o_rv = rom_valid; o_instr = rom_instr; o_addr = rom_addr;
        check("imem_ready", {31'b0, imem_ready}, {31'b0, done && owner == 0});
        check("imem_rdata", imem_rdata, (done && owner == 0) ? rom_rdata : 32'h0);
        check("dmem_ready", {31'b0, dmem_ready}, {31'b0, done && owner == 1});
        check("dmem_rdata", dmem_rdata, (done && owner == 1) ? rom_rdata : 32'h0);
        check("rom_valid", {31'b0, rom_valid}, {31'b0, win >= 0});
        check("rom_instr", {31'b0, rom_instr}, {31'b0, win == 0});
        check("rom_addr", rom_addr, win >= 0 ? caddr[win] : 32'h0);
        seen_ready[0] += int'(imem_ready);
        seen_ready[1] += int'(dmem_ready);
        rom_update();
        if (win >= 0) grants.push_back(win);
        for (int p = 0; p < 2; p++) begin
            if (fresh[p] && win != p) begin
                pv[p] = 1;
                pa[p] = ain[p];
            end
            if (win == p) pv[p] = 0;
        end
        if (win >= 0) begin
            owner = win;
            last  = win;
        end else if (done) owner = -1;
        @(posedge clock); #1;
    endtask
    task automatic idle(input int n);
        repeat (n) cycle(0, 32'h0, 0, 32'h0);
    endtask
    task automatic do_reset(input int n);
        reset = 0;
        imem_valid = 1; dmem_valid = 1; imem_addr = 32'h3C; dmem_addr = 32'h60;
        repeat (n) begin
            rom_drive();
            #3;
            check("rst rom_valid", {31'b0, rom_valid}, 32'h0);
            check("rst rom_instr", {31'b0, rom_instr}, 32'h0);
            check("rst rom_addr", rom_addr, 32'h0);
            check("rst imem_ready", {31'b0, imem_ready}, 32'h0);
            check("rst imem_rdata", imem_rdata, 32'h0);
            check("rst dmem_ready", {31'b0, dmem_ready}, 32'h0);
            check("rst dmem_rdata", dmem_rdata, 32'h0);
            rom_update();
            @(posedge clock); #1;
        end
        reset = 1; imem_valid = 0; dmem_valid = 0;
        owner = -1; last = 1; pv[0] = 0; pv[1] = 0; pa[0] = '0; pa[1] = '0;
    endtask
    initial begin
        int g0, r0, r1, rv_cnt;
        logic [31:0] dlast;
        for (int i = 0; i < 32; i++) rom_mem[i] = $urandom;
        rom_mem[0] = 32'h41014081; rom_mem[15] = 32'h02B74F81; rom_mem[24] = 32'h00000003;
        seen_ready[0] = 0; seen_ready[1] = 0;
        do_reset(2);
        // uncontended fetch
        cycle(1, 32'h0, 0, 32'h0);
        check("fetch issue", {30'b0, o_rv, o_instr}, 32'h3);
        idle(1);
        check("fetch ready", {31'b0, o_iready}, 32'h1);
        check("fetch data", o_irdata, 32'h41014081);
        check("fetch no dready", {31'b0, o_dready}, 32'h0);
        idle(1);
        // simultaneous requests straight after reset
        do_reset(1);
        cycle(1, 32'h3C, 1, 32'h60);
        check("simul I first", {30'b0, o_rv, o_instr}, 32'h3);
        idle(1);
        check("simul I data", o_irdata, 32'h02B74F81);
        check("simul D issue", {30'b0, o_rv, o_instr}, 32'h2);
        idle(1);
        check("simul D data", o_drdata, 32'h00000003);
        idle(1);
        // continuous contention
        g0 = grants.size(); r0 = seen_ready[0]; r1 = seen_ready[1]; rv_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(owner != 0 && !pv[0], $urandom, owner != 1 && !pv[1], $urandom);
            rv_cnt += int'(o_rv);
        end
        idle(2);
        check("contention rom_valid cycles", rv_cnt, 8);
        check("contention grants", grants.size() - g0, 8);
        for (int k = g0 + 1; k < grants.size(); k++)
            check("contention alternate", {31'b0, grants[k] != grants[k-1]}, 32'h1);
        check("contention I readies", seen_ready[0] - r0, 4);
        check("contention D readies", seen_ready[1] - r1, 4);
        // stalled ROM with a load arriving during the stall
        stall = 3;
        cycle(1, 32'h3C, 0, 32'h0);
        check("stall issue", {31'b0, o_rv}, 32'h1);
        idle(1);
        cycle(0, 32'h0, 1, 32'h60);
        check("stall D latched", {31'b0, o_rv}, 32'h0);
        idle(1);
        idle(1);
        check("stall I ready", o_irdata, 32'h02B74F81);
        check("stall D issue", {30'b0, o_rv, o_instr}, 32'h2);
        check("stall D addr", o_addr, 32'h60);
        idle(1);
        check("stall D data", o_drdata, 32'h00000003);
        // reset while a fetch is outstanding and a load is pending
        stall = 1;
        cycle(1, 32'h0, 1, 32'h60);
        check("midrst I issue", {30'b0, o_rv, o_instr}, 32'h3);
        do_reset(1);
        idle(1);
        check("midrst leftover", {30'b0, o_iready, o_dready}, 32'h0);
        idle(1);
        check("midrst D dropped", {31'b0, o_rv}, 32'h0);
        cycle(1, 32'h3C, 0, 32'h0);
        check("midrst refetch issue", {31'b0, o_rv}, 32'h1);
        idle(1);
        check("midrst refetch data", o_irdata, 32'h02B74F81);
        // spurious ROM ready while idle
        spurious = 1;
        idle(1);
        spurious = 0;
        check("spurious ready", {30'b0, o_iready, o_dready}, 32'h0);
        // repeated load valid while the first is still pending
        stall = 2; r1 = seen_ready[1]; dlast = '0;
        cycle(1, 32'h0, 0, 32'h0);
        cycle(0, 32'h0, 1, 32'h60);
        cycle(0, 32'h0, 1, 32'h0);
        idle(1);
        check("violation D addr", o_addr, 32'h60);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            if (o_dready) dlast = o_drdata;
        end
        check("violation D readies", seen_ready[1] - r1, 1);
        check("violation D data", dlast, 32'h00000003);
        // randomized traffic, stalls, spurious readies and protocol violations
        for (int k = 0; k < 400; k++) begin
            if (!rom_busy) stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            spurious = !rom_busy && $urandom_range(0, 7) == 0;
            cycle($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 2) == 0, $urandom);
        end
        spurious = 0; stall = 0;
        idle(6);
        check("final I outstanding", {31'b0, pv[0]}, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
